// File: rtl/munch_pkg.sv
// rtl/munch_pkg.sv - shared encodings, config layout and reset defaults for munch_painter
package munch_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_TAP     = 2'd1,
        MODE_TAP_REV = 2'd2,
        MODE_FADE    = 2'd3
    } mode_e;

    localparam int CFG_W        = 12;
    localparam int CFG_MODE_LSB = 0;
    localparam int CFG_MODE_W   = 2;
    localparam int CFG_SH_LSB   = 2;
    localparam int CFG_SH_W     = 2;
    localparam int CFG_DIV_LSB  = 4;
    localparam int CFG_DIV_W    = 4;
    localparam int CFG_STEP_LSB = 8;
    localparam int CFG_STEP_W   = 3;
    localparam int CFG_DIR_BIT  = 11;

    typedef struct packed {
        logic                  dir;
        logic [CFG_STEP_W-1:0] step;
        logic [CFG_DIV_W-1:0]  div;
        logic [CFG_SH_W-1:0]   sh;
        mode_e                 mode;
    } cfg_t;

    localparam cfg_t CFG_RST_R = '{dir: 1'b0, step: 3'd1, div: 4'd3, sh: 2'd0, mode: MODE_TAP};
    localparam cfg_t CFG_RST_G = '{dir: 1'b0, step: 3'd1, div: 4'd1, sh: 2'd1, mode: MODE_TAP_REV};
    localparam cfg_t CFG_RST_B = '{dir: 1'b0, step: 3'd1, div: 4'd0, sh: 2'd2, mode: MODE_TAP};

    function automatic cfg_t to_cfg(input logic [CFG_W-1:0] w);
        cfg_t c;
        c.mode = mode_e'(w[CFG_MODE_LSB +: CFG_MODE_W]);
        c.sh   = w[CFG_SH_LSB +: CFG_SH_W];
        c.div  = w[CFG_DIV_LSB +: CFG_DIV_W];
        c.step = w[CFG_STEP_LSB +: CFG_STEP_W];
        c.dir  = w[CFG_DIR_BIT];
        return c;
    endfunction

endpackage

// File: rtl/munch_channel.sv
// rtl/munch_channel.sv - one colour channel: config, prescaled position counter, trail decode
module munch_channel import munch_pkg::*; #(
    parameter int   IDX_BITS   = 8,
    parameter int   COLOR_BITS = 8,
    parameter int   TRAIL_LEN  = 8,
    parameter cfg_t RST_CFG    = CFG_RST_R
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  frame_start_i,
    input  logic                  cfg_we_i,
    input  logic [CFG_W-1:0]      cfg_data_i,
    input  logic                  pix_valid_i,
    input  logic [IDX_BITS-1:0]   v_i,
    output logic [COLOR_BITS-1:0] color_o
);

    cfg_t                 pend_q, pend_d, act_q, act_d;
    logic [CFG_DIV_W-1:0] presc_q, presc_d;
    logic [IDX_BITS-1:0]  pos_q, pos_d, d_q, d_d;
    logic [IDX_BITS-1:0]  step_ext, k, low_mask;
    logic                 hit;

    // Prescaler and advance look at the outgoing active config; the copy happens alongside.
    always_comb begin
        pend_d   = pend_q;
        act_d    = act_q;
        presc_d  = presc_q;
        pos_d    = pos_q;
        step_ext = IDX_BITS'(act_q.step);
        if (cfg_we_i) pend_d = to_cfg(cfg_data_i);
        if (frame_start_i) begin
            act_d = pend_q;
            if (presc_q >= act_q.div) begin
                presc_d = '0;
                pos_d   = act_q.dir ? pos_q - step_ext : pos_q + step_ext;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        d_d = pos_q - v_i;
    end

    always_comb begin
        k        = d_q >> act_q.sh;
        low_mask = (IDX_BITS'(1) << act_q.sh) - IDX_BITS'(1);
        hit      = ((d_q & low_mask) == '0) && (k < IDX_BITS'(TRAIL_LEN));
        color_o  = '0;
        if (hit) begin
            case (act_q.mode)
                MODE_OFF:     color_o = '0;
                MODE_TAP:     color_o = {1'b1, {(COLOR_BITS-1){1'b0}}} >> k;
                MODE_TAP_REV: color_o = COLOR_BITS'(1) << k;
                MODE_FADE:    color_o = {COLOR_BITS{1'b1}} >> k;
                default:      color_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pend_q  <= RST_CFG;
            act_q   <= RST_CFG;
            presc_q <= '0;
            pos_q   <= '0;
            d_q     <= '0;
        end else begin
            pend_q  <= pend_d;
            act_q   <= act_d;
            presc_q <= presc_d;
            pos_q   <= pos_d;
            if (pix_valid_i) d_q <= d_d;
        end
    end

endmodule

// File: rtl/munch_painter.sv
// rtl/munch_painter.sv - three-channel x^y comet-trail painter between panel scanner and PWM stage
module munch_painter import munch_pkg::*; #(
    parameter int COORD_BITS = 6,
    parameter int IDX_BITS   = COORD_BITS + 2,
    parameter int COLOR_BITS = 8,
    parameter int TRAIL_LEN  = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [COORD_BITS-1:0]   x,
    input  logic [COORD_BITS-1:0]   y,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_addr,
    input  logic [CFG_W-1:0]        cfg_data,
    output logic                    rgb_valid,
    output logic [3*COLOR_BITS-1:0] rgb24
);

    logic [IDX_BITS-1:0]     v;
    logic [COLOR_BITS-1:0]   red, grn, blu;
    logic                    v1_q, rgb_valid_q;
    logic [3*COLOR_BITS-1:0] rgb24_q;
    logic                    we_r, we_g, we_b;

    assign v    = IDX_BITS'(x ^ y);
    assign we_r = cfg_we && (cfg_addr == 2'd0);
    assign we_g = cfg_we && (cfg_addr == 2'd1);
    assign we_b = cfg_we && (cfg_addr == 2'd2);

    munch_channel #(.IDX_BITS(IDX_BITS), .COLOR_BITS(COLOR_BITS), .TRAIL_LEN(TRAIL_LEN),
                    .RST_CFG(CFG_RST_R)) u_red (
        .clk_i(clk), .resetn_i(resetn), .frame_start_i(frame_start), .cfg_we_i(we_r),
        .cfg_data_i(cfg_data), .pix_valid_i(pix_valid), .v_i(v), .color_o(red));

    munch_channel #(.IDX_BITS(IDX_BITS), .COLOR_BITS(COLOR_BITS), .TRAIL_LEN(TRAIL_LEN),
                    .RST_CFG(CFG_RST_G)) u_grn (
        .clk_i(clk), .resetn_i(resetn), .frame_start_i(frame_start), .cfg_we_i(we_g),
        .cfg_data_i(cfg_data), .pix_valid_i(pix_valid), .v_i(v), .color_o(grn));

    munch_channel #(.IDX_BITS(IDX_BITS), .COLOR_BITS(COLOR_BITS), .TRAIL_LEN(TRAIL_LEN),
                    .RST_CFG(CFG_RST_B)) u_blu (
        .clk_i(clk), .resetn_i(resetn), .frame_start_i(frame_start), .cfg_we_i(we_b),
        .cfg_data_i(cfg_data), .pix_valid_i(pix_valid), .v_i(v), .color_o(blu));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1_q        <= 1'b0;
            rgb_valid_q <= 1'b0;
            rgb24_q     <= '0;
        end else begin
            v1_q        <= pix_valid;
            rgb_valid_q <= v1_q;
            if (v1_q) rgb24_q <= {blu, grn, red};
        end
    end

    assign rgb_valid = rgb_valid_q;
    assign rgb24     = rgb24_q;

endmodule

// File: tb/tb_munch_painter.sv
// tb/tb_munch_painter.sv - directed self-checking bench for munch_painter
module tb_munch_painter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [5:0]  x = '0;
    logic [5:0]  y = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [11:0] cfg_data = '0;
    logic        rgb_valid;
    logic [23:0] rgb24;

    int n_chk = 0;
    int n_bad = 0;

    munch_painter dut (
        .clk(clk), .resetn(resetn), .frame_start(frame_start), .pix_valid(pix_valid),
        .x(x), .y(y), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .rgb_valid(rgb_valid), .rgb24(rgb24));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        cfg_we = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic fs(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [11:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pix(input logic [5:0] px, input logic [5:0] py);
        pix_valid = 1'b1;
        x = px;
        y = py;
        tick();
        pix_valid = 1'b0;
        tick();
    endtask

    logic [5:0]  xs[4];
    logic [23:0] exps[4];

    initial begin
        // reset state and first pixel
        do_reset();
        chk("rst_valid", rgb_valid, 0);
        chk("rst_rgb", rgb24, 24'h0);
        pix(0, 0);
        chk("t1_valid", rgb_valid, 1);
        chk("t1_rgb", rgb24, 24'h800180);

        // four frames: R pos1, G pos2, B pos4; streamed pixels
        fs(4);
        xs = '{6'd0, 6'd1, 6'd2, 6'd4};
        exps = '{24'h400240, 24'h000080, 24'h000100, 24'h800000};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                pix_valid = 1'b1;
                x = xs[i];
                y = 6'd0;
            end else begin
                pix_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk("t2_valid", rgb_valid, 1);
                chk("t2_rgb", rgb24, exps[i-1]);
            end
        end
        tick();
        chk("t2_idle_valid", rgb_valid, 0);
        chk("t2_hold_rgb", rgb24, 24'h800000);

        // behind-head only, dir=1 wrap below zero and back
        do_reset();
        pix(1, 0);
        chk("t3_ahead_miss", rgb24, 24'h000000);
        wr(2'd0, 12'h901);
        fs(2);
        pix(1, 0);
        chk("t3_g_hit", rgb24, 24'h000100);
        pix(2, 0);
        chk("t3_b_hit", rgb24, 24'h800000);
        wr(2'd0, 12'h101);
        fs(2);
        pix(0, 0);
        chk("t3_r_pos255", {24'h0, rgb24[7:0]}, 32'h00);
        fs(1);
        pix(0, 0);
        chk("t3_r_wrap0", {24'h0, rgb24[7:0]}, 32'h80);

        // fade mode applied only at frame_start; shrunken div forces advance
        do_reset();
        fs(8);
        wr(2'd0, 12'h103);
        pix(0, 0);
        chk("t4_pending", {24'h0, rgb24[7:0]}, 32'h20);
        fs(1);
        pix(0, 0);
        chk("t4_fade", {24'h0, rgb24[7:0]}, 32'h3F);
        fs(1);
        pix(0, 0);
        chk("t4_forced_adv", {24'h0, rgb24[7:0]}, 32'h1F);

        // addr 3 ignored; write coincident with frame_start
        do_reset();
        wr(2'd3, 12'h000);
        fs(1);
        pix(0, 0);
        chk("t5_addr3", rgb24, 24'h000180);
        cfg_we = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 12'h103;
        frame_start = 1'b1;
        tick();
        cfg_we = 1'b0;
        frame_start = 1'b0;
        pix(0, 0);
        chk("t5_coinc_old", {24'h0, rgb24[7:0]}, 32'h80);
        fs(1);
        pix(0, 0);
        chk("t5_coinc_new", {24'h0, rgb24[7:0]}, 32'hFF);
        fs(1);
        pix(0, 0);
        chk("t5_adv_d1", {24'h0, rgb24[7:0]}, 32'h7F);
        pix(1, 0);
        chk("t5_adv_d0", {24'h0, rgb24[7:0]}, 32'hFF);

        // asynchronous reset mid-stream
        do_reset();
        fs(4);
        pix_valid = 1'b1;
        x = 6'd0;
        y = 6'd0;
        tick();
        x = 6'd1;
        tick();
        chk("t6_pre_valid", rgb_valid, 1);
        chk("t6_pre_rgb", rgb24, 24'h400240);
        #2 resetn = 1'b0;
        #1;
        chk("t6_async_valid", rgb_valid, 0);
        chk("t6_async_rgb", rgb24, 24'h0);
        pix_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk("t6_discard", rgb_valid, 0);
        pix(0, 0);
        chk("t6_again_valid", rgb_valid, 1);
        chk("t6_again_rgb", rgb24, 24'h800180);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
